// File: rtl/lock_pkg.sv
// Shared encodings for the lock controller: FSM states, output codes, LEDs.
// Optional feature macro: LOCK_ALARM_BLINK_EN (blinking alarm LEDs).
`timescale 1ns/1ps
package lock_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_EDIT   = 3'd1,
    S_CHECK  = 3'd2,
    S_UNLOCK = 3'd3,
    S_ALARM  = 3'd4
  } fsm_t;

  localparam logic [1:0] ST_WAIT   = 2'b00;
  localparam logic [1:0] ST_EDIT   = 2'b01;
  localparam logic [1:0] ST_UNLOCK = 2'b10;
  localparam logic [1:0] ST_ALARM  = 2'b11;

  localparam logic [3:0] LED_WAIT   = 4'b0001;
  localparam logic [3:0] LED_EDIT   = 4'b0011;
  localparam logic [3:0] LED_UNLOCK = 4'b1111;
  localparam logic [3:0] LED_ALARM  = 4'b1010;
  localparam logic [3:0] LED_ON     = 4'b1111;
  localparam logic [3:0] LED_OFF    = 4'b0000;

  localparam int SEC_W = 8;

  function automatic logic [1:0] state_code(fsm_t s);
    logic [1:0] c;
    case (s)
      S_WAIT:   c = ST_WAIT;
      S_EDIT:   c = ST_EDIT;
      S_CHECK:  c = ST_EDIT;
      S_UNLOCK: c = ST_UNLOCK;
      S_ALARM:  c = ST_ALARM;
      default:  c = ST_WAIT;
    endcase
    return c;
  endfunction

  // Alarm pattern at entry: blink starts lit, steady mode shows 1010.
  function automatic logic [3:0] led_code(fsm_t s);
    logic [3:0] l;
    case (s)
      S_WAIT:   l = LED_WAIT;
      S_EDIT:   l = LED_EDIT;
      S_CHECK:  l = LED_EDIT;
      S_UNLOCK: l = LED_UNLOCK;
`ifdef LOCK_ALARM_BLINK_EN
      S_ALARM:  l = LED_ON;
`else
      S_ALARM:  l = LED_ALARM;
`endif
      default:  l = LED_WAIT;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Seconds timer: tick prescaler plus seconds counter, cleared synchronously.
// expire pulses in the last cycle before the seconds count reaches limit.
`timescale 1ns/1ps
module sec_timer
  import lock_pkg::*;
#(
  parameter int TICKS = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [SEC_W-1:0] limit,
  output logic             expire
);

  localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [PW-1:0]    pre;
  logic [SEC_W-1:0] sec;
  logic             wrap;

  assign wrap   = (pre == PW'(TICKS - 1));
  assign expire = wrap && (sec == (limit - 1'b1));

  // Prescaler and saturating seconds count, zeroed on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      sec <= '0;
    end else if (clear) begin
      pre <= '0;
      sec <= '0;
    end else if (wrap) begin
      pre <= '0;
      if (sec != limit)
        sec <= sec + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/lock_controller.sv
// Password lock controller FSM with edit/unlock timeouts and error alarm.
// Optional feature macro: LOCK_ALARM_BLINK_EN (blinking alarm LEDs).
`timescale 1ns/1ps
module lock_controller
  import lock_pkg::*;
#(
  parameter int TICKS_PER_SEC    = 50_000_000,
  parameter int EDIT_TIMEOUT_S   = 10,
  parameter int UNLOCK_TIMEOUT_S = 20,
  parameter int MAX_ERRORS       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       edit_req,
  input  logic       load_pulse,
  input  logic       ok_pulse,
  input  logic       admin_pulse,
  input  logic       check_valid,
  input  logic       check_match,
  output logic [1:0] state,
  output logic       check_req,
  output logic       clear_entry,
  output logic [1:0] err_count,
  output logic [3:0] leds
);

  localparam logic [1:0] MAXE = 2'(MAX_ERRORS);

  fsm_t             fsm;
  logic             restart;
  logic             expire;
  logic [SEC_W-1:0] limit;
  logic [1:0]       err_inc;

`ifdef LOCK_ALARM_BLINK_EN
  localparam int HALF = (TICKS_PER_SEC / 2 < 1) ? 1 : TICKS_PER_SEC / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  logic [BW-1:0] blink_cnt;
`endif

  assign limit = (fsm == S_UNLOCK) ? SEC_W'(UNLOCK_TIMEOUT_S)
                                   : SEC_W'(EDIT_TIMEOUT_S);

  assign err_inc = (err_count == MAXE) ? err_count
                                       : err_count + 2'd1;

  // Timer restarts on every state change and on a digit load in EDIT.
  always_comb begin
    restart = 1'b0;
    case (fsm)
      S_WAIT:   restart = edit_req & ~admin_pulse;
      S_EDIT:   restart = ~admin_pulse &
                          (ok_pulse | expire | load_pulse);
      S_CHECK:  restart = ~admin_pulse & (check_valid | expire);
      S_UNLOCK: restart = ~admin_pulse & (ok_pulse | expire);
      S_ALARM:  restart = admin_pulse;
      default:  restart = 1'b0;
    endcase
  end

  sec_timer #(
    .TICKS (TICKS_PER_SEC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (restart),
    .limit  (limit),
    .expire (expire)
  );

  // Main FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= S_WAIT;
      state       <= ST_WAIT;
      check_req   <= 1'b0;
      clear_entry <= 1'b0;
      err_count   <= 2'd0;
      leds        <= LED_WAIT;
`ifdef LOCK_ALARM_BLINK_EN
      blink_cnt   <= '0;
`endif
    end else begin
      check_req   <= 1'b0;
      clear_entry <= 1'b0;
`ifdef LOCK_ALARM_BLINK_EN
      if (fsm == S_ALARM) begin
        if (blink_cnt == BW'(HALF - 1)) begin
          blink_cnt <= '0;
          leds      <= ~leds;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
      end
`endif
      if (admin_pulse) begin
        err_count <= 2'd0;
        if (fsm == S_ALARM) begin
          fsm         <= S_WAIT;
          state       <= state_code(S_WAIT);
          leds        <= led_code(S_WAIT);
          clear_entry <= 1'b1;
        end
      end else begin
        case (fsm)
          S_WAIT: begin
            if (edit_req) begin
              fsm         <= S_EDIT;
              state       <= state_code(S_EDIT);
              leds        <= led_code(S_EDIT);
              clear_entry <= 1'b1;
            end
          end
          S_EDIT: begin
            if (ok_pulse) begin
              fsm       <= S_CHECK;
              state     <= state_code(S_CHECK);
              leds      <= led_code(S_CHECK);
              check_req <= 1'b1;
            end else if (expire) begin
              fsm         <= S_WAIT;
              state       <= state_code(S_WAIT);
              leds        <= led_code(S_WAIT);
              clear_entry <= 1'b1;
            end
          end
          S_CHECK: begin
            if (check_valid) begin
              if (check_match) begin
                fsm       <= S_UNLOCK;
                state     <= state_code(S_UNLOCK);
                leds      <= led_code(S_UNLOCK);
                err_count <= 2'd0;
              end else begin
                err_count   <= err_inc;
                clear_entry <= 1'b1;
                if (err_inc == MAXE) begin
                  fsm   <= S_ALARM;
                  state <= state_code(S_ALARM);
                  leds  <= led_code(S_ALARM);
                end else begin
                  fsm   <= S_WAIT;
                  state <= state_code(S_WAIT);
                  leds  <= led_code(S_WAIT);
                end
              end
            end else if (expire) begin
              fsm         <= S_WAIT;
              state       <= state_code(S_WAIT);
              leds        <= led_code(S_WAIT);
              clear_entry <= 1'b1;
            end
          end
          S_UNLOCK: begin
            if (ok_pulse || expire) begin
              fsm         <= S_WAIT;
              state       <= state_code(S_WAIT);
              leds        <= led_code(S_WAIT);
              clear_entry <= 1'b1;
            end
          end
          S_ALARM: begin
          end
          default: begin
            fsm   <= S_WAIT;
            state <= state_code(S_WAIT);
            leds  <= led_code(S_WAIT);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lock_controller.sv
// Directed table-driven bench for lock_controller.
// Small timing parameters: 4 ticks/s, 2 s edit, 3 s unlock, 3 errors.
`timescale 1ns/1ps
module tb_lock_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       edit_req = 1'b0;
  logic       load_pulse = 1'b0;
  logic       ok_pulse = 1'b0;
  logic       admin_pulse = 1'b0;
  logic       check_valid = 1'b0;
  logic       check_match = 1'b0;
  logic [1:0] state;
  logic       check_req;
  logic       clear_entry;
  logic [1:0] err_count;
  logic [3:0] leds;

  int checks = 0;
  int errors = 0;

  lock_controller #(
    .TICKS_PER_SEC    (4),
    .EDIT_TIMEOUT_S   (2),
    .UNLOCK_TIMEOUT_S (3),
    .MAX_ERRORS       (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .edit_req    (edit_req),
    .load_pulse  (load_pulse),
    .ok_pulse    (ok_pulse),
    .admin_pulse (admin_pulse),
    .check_valid (check_valid),
    .check_match (check_match),
    .state       (state),
    .check_req   (check_req),
    .clear_entry (clear_entry),
    .err_count   (err_count),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  // inputs: {edit, load, ok, admin, valid, match}
  localparam logic [5:0] I_0 = 6'b000000;
  localparam logic [5:0] I_E = 6'b100000;
  localparam logic [5:0] I_L = 6'b010000;
  localparam logic [5:0] I_O = 6'b001000;
  localparam logic [5:0] I_A = 6'b000100;
  localparam logic [5:0] I_V = 6'b000010;
  localparam logic [5:0] I_M = 6'b000001;

`ifdef LOCK_ALARM_BLINK_EN
  localparam logic [3:0] LA0 = 4'b1111;
  localparam logic [3:0] LA1 = 4'b0000;
`else
  localparam logic [3:0] LA0 = 4'b1010;
  localparam logic [3:0] LA1 = 4'b1010;
`endif

  // expected: {state, check_req, clear_entry, err_count, leds}
  typedef struct {
    int         rep;
    logic [5:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rep, logic [5:0] in, logic [1:0] st,
                              logic req, logic clr, logic [1:0] err,
                              logic [3:0] led);
    vec_t v;
    v.rep = rep;
    v.in  = in;
    v.exp = {st, req, clr, err, led};
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {state, check_req, clear_entry, err_count, leds};
  endfunction

  task automatic chk(string nm, logic [9:0] got, logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b (st,req,clr,err,leds)",
               nm, got, want);
    end
  endtask

  task automatic drive(logic [5:0] in);
    {edit_req, load_pulse, ok_pulse,
     admin_pulse, check_valid, check_match} = in;
  endtask

  task automatic step(string nm, logic [5:0] in, logic [9:0] want);
    @(negedge clk);
    drive(in);
    @(posedge clk);
    #1;
    chk(nm, outs(), want);
  endtask

  initial begin
    // Happy path: edit, confirm, match, unlock timeout of 12 cycles.
    tbl.push_back(mk(1,  I_E,       2'b01, 0, 1, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_O,       2'b01, 1, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_V | I_M, 2'b10, 0, 0, 2'd0, 4'b1111));
    tbl.push_back(mk(11, I_0,       2'b10, 0, 0, 2'd0, 4'b1111));
    tbl.push_back(mk(1,  I_0,       2'b00, 0, 1, 2'd0, 4'b0001));
    // Three wrong checks lead to alarm.
    tbl.push_back(mk(1,  I_E,       2'b01, 0, 1, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_O,       2'b01, 1, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_V,       2'b00, 0, 1, 2'd1, 4'b0001));
    tbl.push_back(mk(1,  I_E,       2'b01, 0, 1, 2'd1, 4'b0011));
    tbl.push_back(mk(1,  I_O,       2'b01, 1, 0, 2'd1, 4'b0011));
    tbl.push_back(mk(1,  I_V,       2'b00, 0, 1, 2'd2, 4'b0001));
    tbl.push_back(mk(1,  I_E,       2'b01, 0, 1, 2'd2, 4'b0011));
    tbl.push_back(mk(1,  I_O,       2'b01, 1, 0, 2'd2, 4'b0011));
    tbl.push_back(mk(1,  I_V,       2'b11, 0, 1, 2'd3, LA0));
    tbl.push_back(mk(1,  I_E,       2'b11, 0, 0, 2'd3, LA0));
    tbl.push_back(mk(1,  I_V | I_M, 2'b11, 0, 0, 2'd3, LA1));
    tbl.push_back(mk(1,  I_0,       2'b11, 0, 0, 2'd3, LA1));
    tbl.push_back(mk(1,  I_0,       2'b11, 0, 0, 2'd3, LA0));
    tbl.push_back(mk(1,  I_A,       2'b00, 0, 1, 2'd0, 4'b0001));
    // Edit timeout after 8 cycles.
    tbl.push_back(mk(1,  I_E,       2'b01, 0, 1, 2'd0, 4'b0011));
    tbl.push_back(mk(7,  I_0,       2'b01, 0, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_0,       2'b00, 0, 1, 2'd0, 4'b0001));
    // Load at cycle 6 pushes the timeout to cycle 14.
    tbl.push_back(mk(1,  I_E,       2'b01, 0, 1, 2'd0, 4'b0011));
    tbl.push_back(mk(5,  I_0,       2'b01, 0, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_L,       2'b01, 0, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(7,  I_0,       2'b01, 0, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_0,       2'b00, 0, 1, 2'd0, 4'b0001));
    // Admin in EDIT clears errors only; CHECK times out.
    tbl.push_back(mk(1,  I_E,       2'b01, 0, 1, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_O,       2'b01, 1, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_V,       2'b00, 0, 1, 2'd1, 4'b0001));
    tbl.push_back(mk(1,  I_E,       2'b01, 0, 1, 2'd1, 4'b0011));
    tbl.push_back(mk(1,  I_A,       2'b01, 0, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_O,       2'b01, 1, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(7,  I_0,       2'b01, 0, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_0,       2'b00, 0, 1, 2'd0, 4'b0001));
    // ok on the expiry cycle in EDIT wins.
    tbl.push_back(mk(1,  I_E,       2'b01, 0, 1, 2'd0, 4'b0011));
    tbl.push_back(mk(7,  I_0,       2'b01, 0, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_O,       2'b01, 1, 0, 2'd0, 4'b0011));
    // ok on the expiry cycle in UNLOCK: one exit, one clear pulse.
    tbl.push_back(mk(1,  I_V | I_M, 2'b10, 0, 0, 2'd0, 4'b1111));
    tbl.push_back(mk(11, I_0,       2'b10, 0, 0, 2'd0, 4'b1111));
    tbl.push_back(mk(1,  I_O,       2'b00, 0, 1, 2'd0, 4'b0001));
    tbl.push_back(mk(1,  I_0,       2'b00, 0, 0, 2'd0, 4'b0001));
    // Early ok in UNLOCK.
    tbl.push_back(mk(1,  I_E,       2'b01, 0, 1, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_O,       2'b01, 1, 0, 2'd0, 4'b0011));
    tbl.push_back(mk(1,  I_V | I_M, 2'b10, 0, 0, 2'd0, 4'b1111));
    tbl.push_back(mk(1,  I_O,       2'b00, 0, 1, 2'd0, 4'b0001));

    // Reset state while rst is held.
    drive(I_0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs(), {2'b00, 1'b0, 1'b0, 2'd0, 4'b0001});
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++)
        step($sformatf("row%0d.%0d", i, k), tbl[i].in, tbl[i].exp);
    end

    // Reset in the middle of a CHECK with one error recorded.
    step("rs_e1", I_E, {2'b01, 1'b0, 1'b1, 2'd0, 4'b0011});
    step("rs_o1", I_O, {2'b01, 1'b1, 1'b0, 2'd0, 4'b0011});
    step("rs_v1", I_V, {2'b00, 1'b0, 1'b1, 2'd1, 4'b0001});
    step("rs_e2", I_E, {2'b01, 1'b0, 1'b1, 2'd1, 4'b0011});
    step("rs_o2", I_O, {2'b01, 1'b1, 1'b0, 2'd1, 4'b0011});
    @(negedge clk);
    drive(I_0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", outs(), {2'b00, 1'b0, 1'b0, 2'd0, 4'b0001});
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_match", I_V | I_M,
         {2'b00, 1'b0, 1'b0, 2'd0, 4'b0001});
    step("post_rst_miss", I_V,
         {2'b00, 1'b0, 1'b0, 2'd0, 4'b0001});
    step("post_rst_idle", I_0,
         {2'b00, 1'b0, 1'b0, 2'd0, 4'b0001});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 Parameter TICKS_PER_SEC, default 50_000_000: clk cycles per second.
REQ-002 Parameter EDIT_TIMEOUT_S, default 10: seconds of edit inactivity before returning to waiting.
REQ-003 Parameter UNLOCK_TIMEOUT_S, default 20: seconds the lock stays unlocked.
REQ-004 Parameter MAX_ERRORS, default 3: consecutive wrong checks that trigger the alarm (range 1..3).
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port edit_req, input, 1: one-cycle pulse (debounced edit switch toggle).
REQ-008 Port load_pulse, input, 1: one-cycle pulse per digit loaded.
REQ-009 Port ok_pulse, input, 1: one-cycle confirm pulse.
REQ-010 Port admin_pulse, input, 1: one-cycle administrator clear pulse.
REQ-011 Port check_valid, input, 1: one-cycle pulse, password comparator result ready.
REQ-012 Port check_match, input, 1: comparator result, qualified by check_valid.
REQ-013 Port state, output, 2: 00 waiting, 01 editing, 10 unlocked, 11 alarming.
REQ-014 Port check_req, output, 1: one-cycle pulse requesting a password comparison.
REQ-015 Port clear_entry, output, 1: one-cycle pulse clearing the entry register.
REQ-016 Port err_count, output, 2: consecutive wrong-check count.
REQ-017 Port leds, output, 4: active-high state indicator LEDs.

Function
REQ-018 The FSM SHALL have the states WAIT, EDIT, CHECK, UNLOCK and ALARM; CHECK reports state=01.
REQ-019 In WAIT, edit_req SHALL move the FSM to EDIT and assert clear_entry in that cycle; all other inputs except admin_pulse are ignored.
REQ-020 In EDIT, ok_pulse SHALL assert check_req for one cycle and move the FSM to CHECK.
REQ-021 In EDIT, load_pulse SHALL restart the edit timer.
REQ-022 In EDIT or CHECK, expiry of EDIT_TIMEOUT_S SHALL return the FSM to WAIT with clear_entry asserted.
REQ-023 In EDIT, if ok_pulse and timer expiry coincide, ok_pulse wins.
REQ-024 In CHECK, check_valid with check_match=1 SHALL move the FSM to UNLOCK and clear err_count to 0.
REQ-025 In CHECK, check_valid with check_match=0 SHALL increment err_count and assert clear_entry.
REQ-026 After that increment, the FSM SHALL go to ALARM if the new count equals MAX_ERRORS, otherwise to WAIT.
REQ-027 check_valid outside CHECK SHALL be ignored.
REQ-028 In UNLOCK, ok_pulse or expiry of UNLOCK_TIMEOUT_S SHALL return the FSM to WAIT with clear_entry asserted; if both coincide, exactly one transition occurs.
REQ-029 ALARM SHALL be left only by admin_pulse, which goes to WAIT, clears err_count and asserts clear_entry.
REQ-030 admin_pulse in any other state SHALL clear err_count and leave the state unchanged.
REQ-031 err_count SHALL saturate at MAX_ERRORS and never wrap.
REQ-032 The timer SHALL be a prescaler counting 0..TICKS_PER_SEC-1 plus a seconds counter.
REQ-033 The timer SHALL be zeroed on every state entry; expiry is a one-cycle pulse when the seconds count reaches the limit.
REQ-034 leds SHALL show WAIT=0001, EDIT/CHECK=0011, UNLOCK=1111, ALARM per REQ-038.
REQ-035 Outputs SHALL be registered; state changes one cycle after the triggering input edge.

Reset
REQ-036 While rst=1, the FSM SHALL be in WAIT, err_count=0, check_req=0, clear_entry=0, leds=0001, and the timer counters SHALL be 0.
REQ-037 Reset mid-operation (including in CHECK or ALARM) SHALL abandon the operation; a pending check_valid after reset is ignored.

Configuration
REQ-038 With LOCK_ALARM_BLINK_EN defined, leds SHALL toggle between 1111 and 0000 every TICKS_PER_SEC/2 cycles in ALARM (starting at 1111 on entry); without it, leds SHALL hold 1010 steadily in ALARM.

Structure
REQ-039 Package lock_pkg SHALL hold the state encoding constants (2-bit output codes and internal FSM encoding) and the LED pattern constants.
REQ-040 The seconds timer SHALL be a sub-module sec_timer (clear, limit in, expire pulse out), instantiated once.

Verification (TICKS_PER_SEC=4, EDIT_TIMEOUT_S=2, UNLOCK_TIMEOUT_S=3, MAX_ERRORS=3)
REQ-041 edit_req, then ok_pulse, then check_valid=1 with check_match=1 -> state 00->01->10, err_count=0, leds=1111, return to 00 after 12 cycles.
REQ-042 Three edit/ok/check_valid cycles with check_match=0 -> err_count 1,2,3, state=11 after the third; edit_req then ignored; admin_pulse -> state=00, err_count=0.
REQ-043 edit_req then no input -> state=00 with clear_entry pulse after 8 cycles; with load_pulse at cycle 6, return occurs at cycle 14.
REQ-044 In UNLOCK, ok_pulse on the same cycle as timer expiry -> single transition to 00, one clear_entry pulse.
REQ-045 rst asserted asynchronously mid-clock while in CHECK -> immediate state=00, err_count=0; a check_valid arriving after reset causes no change.
REQ-046 ALARM with and without LOCK_ALARM_BLINK_EN -> leds toggle 1111/0000 every 2 cycles vs. constant 1010.
